fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage at the front of the pipeline. It owns the fetch PC and issues halfword (Thumb) requests to instruction memory over a req/gnt/rvalid handshake. Returned halfwords are buffered in a small in-order queue and presented to decode with their PC. It consumes the taken-branch/flush redirect and target PC produced by the execute-stage branch controller, and discards all stale in-flight and buffered fetches.

Parameters:
WORD, 32, datapath/address width
FIFO_DEPTH, 4, instruction queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk_i  input  1  clock, all state on rising edge
reset_n_i  input  1  synchronous active-low reset
take_branch_i  input  1  redirect from branch controller (taken branch, already qualified by valid)
branch_target_i  input  WORD  redirect target PC
imem_req_o  output  1  fetch request valid
imem_addr_o  output  WORD  halfword-aligned fetch address
imem_gnt_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  read data valid, in request order
imem_rdata_i  input  16  returned halfword
stall_i  input  1  decode cannot accept this cycle
instruction_o  output  16  instruction at queue head
program_counter_o  output  WORD  address of instruction_o
is_valid_o  output  1  instruction_o/program_counter_o valid

Behaviour:
- Reset (reset_n_i=0 at edge): fetch_pc=RESET_PC, queue empty, inflight=0, discard=0. While reset_n_i=0 (combinationally): imem_req_o=0, is_valid_o=0. First request is possible in the first cycle after reset is released.
- Credit: imem_req_o = (count + inflight < FIFO_DEPTH) & ~take_branch_i. The queue can therefore never overflow; memory is never back-pressured on rvalid.
- imem_addr_o = fetch_pc. Bit 0 is always 0. Address is held stable while req=1 and gnt=0, unless a redirect occurs.
- Request accepted on req & gnt: fetch_pc += 2 (wraps modulo 2^WORD), inflight += 1.
- Response on rvalid: inflight -= 1. If discard>0, drop the data and decrement discard. Otherwise push {rdata, pc}; the pc tag comes from a separate response-PC counter, which advances by 2 per pushed entry.
- Output: is_valid_o = ~empty & ~take_branch_i. instruction_o/program_counter_o show the queue head. Pop on is_valid_o & ~stall_i. Same-cycle push and pop are permitted, and count is unchanged.
- Redirect (take_branch_i=1):
  - imem_req_o=0 that cycle, so no grant can occur.
  - Next cycle: fetch_pc and response-PC = branch_target_i & ~1, queue cleared, no pop that cycle.
  - discard_next = inflight_next, where inflight_next already accounts for this cycle's rvalid. An rvalid arriving in the redirect cycle is dropped and is not pushed.
- Back-to-back redirects: each reloads the PCs, and discard covers every request still in flight.
- stall_i holds the head stable. Fetching continues until credits are exhausted.
- Reset mid-operation: all state is cleared. Responses arriving after reset for pre-reset requests are the memory's responsibility; memory is reset together with this block.
- Latency: grant at cycle N with rvalid at N+k gives is_valid_o at N+k+1 (registered queue).

Test Plan:
- Reset release, gnt=1 always, 1-cycle rvalid, stall_i=0 -> addresses 0,2,4,6…; outputs PC 0,2,4 with instructions matching the memory image; is_valid_o first high 2 cycles after the first grant.
- stall_i=1 held with gnt=1 -> exactly FIFO_DEPTH grants total (queue + inflight), then imem_req_o=0; head stays at PC 0. Release stall -> in-order drain, no loss or duplication.
- gnt=0 for 5 cycles with req high -> imem_addr_o stable at the same value throughout; fetch_pc unchanged until gnt.
- 3 requests in flight (rvalid delay 4), take_branch_i with target 0x0000_0101 -> next request addr 0x100; the 3 stale responses are dropped; first is_valid_o shows PC 0x100.
- take_branch_i in the same cycle as an rvalid that would have been pushed -> that data never appears; queue is empty the next cycle.
- Drive fetch_pc to 0xFFFF_FFFE via a redirect -> next address 0x0000_0000 (wrap); redirect 2 cycles apart -> only the second target's instructions are output.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Thumb halfword fetch stage with credit-limited request issue and in-order instruction queue
module fetch_unit #(
  parameter int              WORD       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [WORD-1:0] RESET_PC   = '0
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            take_branch_i,
  input  logic [WORD-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [WORD-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [15:0]     imem_rdata_i,
  input  logic            stall_i,
  output logic [15:0]     instruction_o,
  output logic [WORD-1:0] program_counter_o,
  output logic            is_valid_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [WORD-1:0] HALF_C  = WORD'(2);
  localparam logic [WORD-1:0] ALIGN_C = ~WORD'(1);

  logic [WORD-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [15:0]     instr_mem_q [FIFO_DEPTH];
  logic [WORD-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [CW:0]     credit_used;
  logic            grant, push, pop;

  // Queue slots plus outstanding requests never exceed depth, so rvalid needs no back-pressure.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req_o  = reset_n_i & ~take_branch_i & (credit_used < DEPTH_C);
  assign imem_addr_o = fetch_pc_q;
  assign is_valid_o  = reset_n_i & (count_q != '0) & ~take_branch_i;

  assign grant = imem_req_o & imem_gnt_i;
  assign pop   = is_valid_o & ~stall_i;
  assign push  = reset_n_i & imem_rvalid_i & (discard_q == '0) & ~take_branch_i;

  assign instruction_o     = instr_mem_q[rd_ptr_q];
  assign program_counter_o = pc_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid_i);

    if (take_branch_i) begin
      // Everything still outstanding after this cycle's response is stale.
      fetch_pc_d = branch_target_i & ALIGN_C;
      resp_pc_d  = branch_target_i & ALIGN_C;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = inflight_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + HALF_C;
      if (push) begin
        resp_pc_d = resp_pc_q + HALF_C;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (imem_rvalid_i && discard_q != '0) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      fetch_pc_q <= RESET_PC & ALIGN_C;
      resp_pc_q  <= RESET_PC & ALIGN_C;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end
endmodule
